// File: rtl/rotate_pipe_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rotate_pipe_pkg
//  Description : Shared constants and helper function for the pipelined
//                barrel rotator (direction/mode encodings, ceiling log2).
//  Revision    : 1.0 - initial release
// ============================================================================
package rotate_pipe_pkg;

    localparam logic DIR_LEFT    = 1'b1;
    localparam logic DIR_RIGHT   = 1'b0;
    localparam logic MODE_ROTATE = 1'b0;
    localparam logic MODE_SHIFT  = 1'b1;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rotate_pipe_level.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rotate_pipe_level
//  Description : One combinational mux level of the barrel rotator. When
//                enabled, moves the vector by DIST units left or right,
//                either wrapping (rotate) or filling with zero (shift).
//  Ports       : i_data  - input vector, unit 0 at bits [0:UNIT_SIZE-1]
//                i_en    - apply this level (rotation bit set)
//                i_dir   - 1 = left, 0 = right
//                i_shift - 1 = zero-fill shift, 0 = rotate
//                o_data  - output vector
//  Revision    : 1.0 - initial release
// ============================================================================
module rotate_pipe_level
    import rotate_pipe_pkg::*;
#(
    parameter int UNIT_SIZE  = 8,
    parameter int NUM_UNITS  = 4,
    parameter int INPUT_SIZE = UNIT_SIZE * NUM_UNITS,
    parameter int DIST       = 1
) (
    input  logic [0:INPUT_SIZE-1] i_data,
    input  logic                  i_en,
    input  logic                  i_dir,
    input  logic                  i_shift,
    output logic [0:INPUT_SIZE-1] o_data
);

    // Rotation wraps, so only the distance modulo the vector length matters.
    localparam int c_DIST_MOD = DIST % NUM_UNITS;

    for (genvar j = 0; j < NUM_UNITS; j++) begin : g_unit
        localparam int c_ROT_L     = (j + c_DIST_MOD) % NUM_UNITS;
        localparam int c_ROT_R     = (j + NUM_UNITS - c_DIST_MOD) % NUM_UNITS;
        // Shift sources falling outside the vector produce zero.
        localparam bit c_SHL_OK    = (j + DIST) < NUM_UNITS;
        localparam bit c_SHR_OK    = j >= DIST;
        localparam int c_SHL_SRC   = c_SHL_OK ? (j + DIST) : 0;
        localparam int c_SHR_SRC   = c_SHR_OK ? (j - DIST) : 0;

        logic [UNIT_SIZE-1:0] w_moved;

        always_comb begin
            w_moved = '0;
            if (i_dir == DIR_LEFT) begin
                if (i_shift == MODE_SHIFT) begin
                    if (c_SHL_OK) begin
                        w_moved = i_data[c_SHL_SRC*UNIT_SIZE +: UNIT_SIZE];
                    end
                end else begin
                    w_moved = i_data[c_ROT_L*UNIT_SIZE +: UNIT_SIZE];
                end
            end else begin
                if (i_shift == MODE_SHIFT) begin
                    if (c_SHR_OK) begin
                        w_moved = i_data[c_SHR_SRC*UNIT_SIZE +: UNIT_SIZE];
                    end
                end else begin
                    w_moved = i_data[c_ROT_R*UNIT_SIZE +: UNIT_SIZE];
                end
            end
        end

        assign o_data[j*UNIT_SIZE +: UNIT_SIZE] =
            i_en ? w_moved : i_data[j*UNIT_SIZE +: UNIT_SIZE];
    end

endmodule
`default_nettype wire

// File: rtl/rotate_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : rotate_pipe
//  Description : Pipelined barrel rotator/shifter over NUM_UNITS units of
//                UNIT_SIZE bits. Log levels are applied LSB first with a
//                register after every REG_EVERY levels (the last group is
//                always registered). valid/ready handshake, 1 word/cycle.
//  Ports       : clk, reset (async, active high)
//                in_data/in_rotation/in_dir/in_shift/in_tag/in_vld/in_rdy
//                out_data/out_tag/out_vld/out_rdy
//  Revision    : 1.0 - initial release
// ============================================================================
module rotate_pipe
    import rotate_pipe_pkg::*;
#(
    parameter int UNIT_SIZE   = 8,
    parameter int NUM_UNITS   = 4,
    parameter int INPUT_SIZE  = UNIT_SIZE * NUM_UNITS,
    parameter int ROTATE_SIZE = log2_ceil(NUM_UNITS),
    parameter int REG_EVERY   = 1,
    parameter int TAG_WIDTH   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:INPUT_SIZE-1]  in_data,
    input  logic [ROTATE_SIZE-1:0] in_rotation,
    input  logic                   in_dir,
    input  logic                   in_shift,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic [0:INPUT_SIZE-1]  out_data,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   out_vld,
    input  logic                   out_rdy
);

    localparam int NUM_REGS     = (ROTATE_SIZE + REG_EVERY - 1) / REG_EVERY;
    // Control word: {dir, shift, rotation}
    localparam int c_CTRL_W     = ROTATE_SIZE + 2;
    localparam int c_DIR_BIT    = ROTATE_SIZE + 1;
    localparam int c_SHIFT_BIT  = ROTATE_SIZE;

    // Index g is the source feeding register group g; index NUM_REGS is the
    // output of the final register.
    logic [0:INPUT_SIZE-1] w_src_data [0:NUM_REGS];
    logic [TAG_WIDTH-1:0]  w_src_tag  [0:NUM_REGS];
    logic [NUM_REGS:0]     w_src_vld;
    logic [c_CTRL_W-1:0]   w_src_ctrl [0:NUM_REGS-1];
    logic [NUM_REGS:0]     w_rdy;
    logic [0:INPUT_SIZE-1] w_lvl      [0:ROTATE_SIZE-1];

    assign w_src_data[0] = in_data;
    assign w_src_tag[0]  = in_tag;
    assign w_src_vld[0]  = in_vld;
    assign w_src_ctrl[0] = {in_dir, in_shift, in_rotation};

    // A stage may load when empty or when its occupant moves on this edge.
    always_comb begin
        w_rdy[NUM_REGS] = out_rdy;
        for (int s = NUM_REGS - 1; s >= 0; s--) begin
            w_rdy[s] = !w_src_vld[s+1] || w_rdy[s+1];
        end
    end

    assign in_rdy   = w_rdy[0];
    assign out_data = w_src_data[NUM_REGS];
    assign out_tag  = w_src_tag[NUM_REGS];
    assign out_vld  = w_src_vld[NUM_REGS];

    for (genvar k = 0; k < ROTATE_SIZE; k++) begin : g_level
        localparam int c_GRP = k / REG_EVERY;
        logic [0:INPUT_SIZE-1] w_in;

        // First level of a group reads the group's register; others chain.
        if (k % REG_EVERY == 0) begin : g_first
            assign w_in = w_src_data[c_GRP];
        end else begin : g_chain
            assign w_in = w_lvl[k-1];
        end

        rotate_pipe_level #(
            .UNIT_SIZE  (UNIT_SIZE),
            .NUM_UNITS  (NUM_UNITS),
            .INPUT_SIZE (INPUT_SIZE),
            .DIST       (1 << k)
        ) u_level (
            .i_data  (w_in),
            .i_en    (w_src_ctrl[c_GRP][k]),
            .i_dir   (w_src_ctrl[c_GRP][c_DIR_BIT]),
            .i_shift (w_src_ctrl[c_GRP][c_SHIFT_BIT]),
            .o_data  (w_lvl[k])
        );
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_stage
        localparam int c_LAST_LVL =
            (((g + 1) * REG_EVERY < ROTATE_SIZE) ? (g + 1) * REG_EVERY : ROTATE_SIZE) - 1;

        logic                  r_vld;
        logic [0:INPUT_SIZE-1] r_data;
        logic [TAG_WIDTH-1:0]  r_tag;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_tag  <= '0;
            end else if (w_rdy[g]) begin
                r_vld <= w_src_vld[g];
                if (w_src_vld[g]) begin
                    r_data <= w_lvl[c_LAST_LVL];
                    r_tag  <= w_src_tag[g];
                end
            end
        end

        assign w_src_vld[g+1]  = r_vld;
        assign w_src_data[g+1] = r_data;
        assign w_src_tag[g+1]  = r_tag;

        // Control only needs to travel to stages that still have levels.
        if (g < NUM_REGS - 1) begin : g_ctrl
            logic [c_CTRL_W-1:0] r_ctrl;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ctrl <= '0;
                end else if (w_rdy[g] && w_src_vld[g]) begin
                    r_ctrl <= w_src_ctrl[g];
                end
            end

            assign w_src_ctrl[g+1] = r_ctrl;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rotate_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rotate_pipe
//  Description : Self-checking bench for rotate_pipe. Two instances: 4x8-bit
//                with one level per register, and 5x4-bit with two levels
//                per register. A unit-indexed reference model feeds a
//                scoreboard checked every cycle; directed cases pin literals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rotate_pipe;

    localparam int A_U = 8, A_N = 4, A_W = 32, A_RS = 2, A_TW = 8, A_LAT = 2;
    localparam int B_U = 4, B_N = 5, B_W = 20, B_RS = 3, B_TW = 4, B_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [0:A_W-1]  a_in_data = '0, a_out_data;
    logic [A_RS-1:0] a_rot = '0;
    logic            a_dir = 1'b0, a_shift = 1'b0, a_in_vld = 1'b0, a_out_rdy = 1'b1;
    logic            a_in_rdy, a_out_vld;
    logic [A_TW-1:0] a_in_tag = '0, a_out_tag;

    logic [0:B_W-1]  b_in_data = '0, b_out_data;
    logic [B_RS-1:0] b_rot = '0;
    logic            b_dir = 1'b0, b_shift = 1'b0, b_in_vld = 1'b0, b_out_rdy = 1'b1;
    logic            b_in_rdy, b_out_vld;
    logic [B_TW-1:0] b_in_tag = '0, b_out_tag;

    rotate_pipe #(.UNIT_SIZE(A_U), .NUM_UNITS(A_N), .REG_EVERY(1), .TAG_WIDTH(A_TW)) dut_a (
        .clk(clk), .reset(rst), .in_data(a_in_data), .in_rotation(a_rot), .in_dir(a_dir),
        .in_shift(a_shift), .in_tag(a_in_tag), .in_vld(a_in_vld), .in_rdy(a_in_rdy),
        .out_data(a_out_data), .out_tag(a_out_tag), .out_vld(a_out_vld), .out_rdy(a_out_rdy));

    rotate_pipe #(.UNIT_SIZE(B_U), .NUM_UNITS(B_N), .REG_EVERY(2), .TAG_WIDTH(B_TW)) dut_b (
        .clk(clk), .reset(rst), .in_data(b_in_data), .in_rotation(b_rot), .in_dir(b_dir),
        .in_shift(b_shift), .in_tag(b_in_tag), .in_vld(b_in_vld), .in_rdy(b_in_rdy),
        .out_data(b_out_data), .out_tag(b_out_tag), .out_vld(b_out_vld), .out_rdy(b_out_rdy));

    // Reference: unit j of the result, unit 0 being the most significant.
    function automatic logic [63:0] model(input logic [63:0] d, input int rot, input bit dir,
                                          input bit sh, input int n, input int u);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < n; j++) begin
            int src;
            logic [63:0] unit;
            if (sh) src = dir ? j + rot : j - rot;
            else    src = dir ? (j + rot % n) % n : (j - rot % n + n) % n;
            if (src >= 0 && src < n) unit = (d >> ((n - 1 - src) * u)) & ((64'd1 << u) - 1);
            else                     unit = '0;
            r = r | (unit << ((n - 1 - j) * u));
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic [7:0]  tag;
    } item_t;

    item_t qa[$];
    item_t qb[$];
    bit          a_hold = 1'b0, b_hold = 1'b0;
    logic [63:0] a_hold_data = '0, b_hold_data = '0;
    logic [7:0]  a_hold_tag = '0, b_hold_tag = '0;
    int a_pops = 0, b_pops = 0, a_last_pop = 0;
    int a_acc_cyc = 0, b_acc_cyc = 0;

    // Scoreboard: checked on every falling edge, away from the active edge.
    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            qa.delete();
            qb.delete();
            a_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            if (a_hold) begin
                check("a_stall_vld", a_out_vld, 1);
                check("a_stall_data", a_out_data, a_hold_data);
                check("a_stall_tag", a_out_tag, a_hold_tag);
            end
            if (a_out_vld) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_spurious_out: got data %0h with nothing outstanding", a_out_data);
                end else begin
                    check("a_data", a_out_data, qa[0].data);
                    check("a_tag", a_out_tag, qa[0].tag);
                end
            end
            if (a_out_rdy) check("a_in_rdy", a_in_rdy, 1);
            if (a_out_vld && a_out_rdy && qa.size() > 0) begin
                void'(qa.pop_front());
                a_pops++;
                a_last_pop = cyc;
            end
            a_hold      = a_out_vld && !a_out_rdy;
            a_hold_data = a_out_data;
            a_hold_tag  = a_out_tag;
            if (a_in_vld && a_in_rdy) begin
                it.data = model(a_in_data, int'(a_rot), a_dir, a_shift, A_N, A_U);
                it.tag  = a_in_tag;
                qa.push_back(it);
            end

            if (b_hold) begin
                check("b_stall_vld", b_out_vld, 1);
                check("b_stall_data", b_out_data, b_hold_data);
                check("b_stall_tag", b_out_tag, b_hold_tag);
            end
            if (b_out_vld) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_spurious_out: got data %0h with nothing outstanding", b_out_data);
                end else begin
                    check("b_data", b_out_data, qb[0].data);
                    check("b_tag", b_out_tag, qb[0].tag);
                end
            end
            if (b_out_rdy) check("b_in_rdy", b_in_rdy, 1);
            if (b_out_vld && b_out_rdy && qb.size() > 0) begin
                void'(qb.pop_front());
                b_pops++;
            end
            b_hold      = b_out_vld && !b_out_rdy;
            b_hold_data = b_out_data;
            b_hold_tag  = {4'b0, b_out_tag};
            if (b_in_vld && b_in_rdy) begin
                it.data = model(b_in_data, int'(b_rot), b_dir, b_shift, B_N, B_U);
                it.tag  = {4'b0, b_in_tag};
                qb.push_back(it);
            end
        end
    end

    task automatic send_a(input logic [31:0] d, input int rot, input bit dir, input bit sh,
                          input logic [7:0] tag);
        int n;
        bit done;
        a_in_data = d; a_rot = rot[A_RS-1:0]; a_dir = dir; a_shift = sh; a_in_tag = tag;
        a_in_vld = 1'b1;
        n = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (a_in_rdy) begin
                a_acc_cyc = cyc;
                done = 1'b1;
            end else if (++n > 200) begin
                tests++; fails++;
                $display("FAIL a_send_timeout: in_rdy stayed %0d for %0d cycles", a_in_rdy, n);
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        a_in_vld = 1'b0;
    endtask

    task automatic send_b(input logic [19:0] d, input int rot, input bit dir, input bit sh,
                          input logic [3:0] tag);
        int n;
        bit done;
        b_in_data = d; b_rot = rot[B_RS-1:0]; b_dir = dir; b_shift = sh; b_in_tag = tag;
        b_in_vld = 1'b1;
        n = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (b_in_rdy) begin
                b_acc_cyc = cyc;
                done = 1'b1;
            end else if (++n > 200) begin
                tests++; fails++;
                $display("FAIL b_send_timeout: in_rdy stayed %0d for %0d cycles", b_in_rdy, n);
                done = 1'b1;
            end
        end
        @(posedge clk); #1;
        b_in_vld = 1'b0;
    endtask

    // Waits for the next output word; checks latency, literal data and tag.
    task automatic expect_a(input string name, input logic [31:0] exp, input logic [7:0] tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_out_vld && n < 50);
        check({name, "_lat"}, cyc - a_acc_cyc, A_LAT);
        check(name, a_out_data, exp);
        check({name, "_tag"}, a_out_tag, tag);
        @(posedge clk); #1;
    endtask

    task automatic expect_b(input string name, input logic [19:0] exp, input logic [3:0] tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_out_vld && n < 50);
        check({name, "_lat"}, cyc - b_acc_cyc, B_LAT);
        check(name, b_out_data, exp);
        check({name, "_tag"}, b_out_tag, tag);
        @(posedge clk); #1;
    endtask

    task automatic drain(input int which);
        int n;
        n = 0;
        while (((which == 0) ? qa.size() : qb.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check((which == 0) ? "a_drain" : "b_drain", (which == 0) ? qa.size() : qb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [31:0] d_data [7] = '{32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344,
                                32'h11223344, 32'h11223344, 32'h11223344};
    int          d_rot  [7] = '{1, 1, 0, 0, 3, 2, 3};
    bit          d_dir  [7] = '{1, 0, 1, 0, 1, 0, 0};
    bit          d_sh   [7] = '{0, 0, 0, 1, 1, 1, 0};
    logic [31:0] d_exp  [7] = '{32'h22334411, 32'h44112233, 32'h11223344, 32'h11223344,
                                32'h44000000, 32'h00001122, 32'h22334411};
    bit          pat    [7] = '{1, 0, 1, 1, 0, 0, 1};

    initial begin
        int p0, c0;
        bit done;

        // Reset state
        @(negedge clk);
        check("rst_a_vld", a_out_vld, 0);
        check("rst_a_data", a_out_data, 0);
        check("rst_a_tag", a_out_tag, 0);
        check("rst_b_vld", b_out_vld, 0);
        check("rst_b_data", b_out_data, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(negedge clk);
        check("rel_a_in_rdy", a_in_rdy, 1);
        check("rel_b_in_rdy", b_in_rdy, 1);
        check("rel_a_vld", a_out_vld, 0);
        @(posedge clk); #1;

        // Directed literal cases, out_rdy high
        for (int i = 0; i < 7; i++) begin
            send_a(d_data[i], d_rot[i], d_dir[i], d_sh[i], 8'(8'h50 + i));
            expect_a($sformatf("a_dir%0d", i), d_exp[i], 8'(8'h50 + i));
        end

        // Stream of 16 words under a backpressure pattern
        p0 = a_pops;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    send_a($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 8'(i));
                done = 1'b1;
            end
            begin
                for (int i = 0; !done && i < 400; i++) begin
                    a_out_rdy = pat[i % 7];
                    @(posedge clk); #1;
                end
                a_out_rdy = 1'b1;
            end
        join
        drain(0);
        check("a_stream_count", a_pops - p0, 16);

        // Back-to-back throughput with out_rdy held high
        a_out_rdy = 1'b1;
        p0 = a_pops;
        c0 = 0;
        for (int i = 0; i < 8; i++) begin
            send_a($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 8'(8'h80 + i));
            if (i == 0) c0 = a_acc_cyc;
        end
        drain(0);
        check("a_tput_count", a_pops - p0, 8);
        check("a_tput_last", a_last_pop - c0, A_LAT + 7);

        // Random traffic with random idle gaps and random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send_a($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 8'($urandom));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    a_out_rdy = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                a_out_rdy = 1'b1;
            end
        join
        drain(0);

        // Reset with two words in flight and the output stalled
        a_out_rdy = 1'b0;
        send_a(32'hDEADBEEF, 1, 1, 0, 8'hAA);
        send_a(32'hCAFEF00D, 2, 0, 0, 8'hBB);
        #1;
        rst = 1'b1;
        #1;
        check("arst_a_vld", a_out_vld, 0);
        check("arst_a_data", a_out_data, 0);
        check("arst_a_tag", a_out_tag, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        a_out_rdy = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_in_rdy", a_in_rdy, 1);
        check("arst_no_stale", a_out_vld, 0);
        @(posedge clk); #1;

        // Non-power-of-two instance, two levels per register
        send_b(20'h12345, 7, 1, 0, 4'h3);
        expect_b("b_rot7_left", 20'h34512, 4'h3);
        send_b(20'h12345, 7, 1, 1, 4'h4);
        expect_b("b_shift7_left", 20'h00000, 4'h4);
        send_b(20'h12345, 1, 0, 0, 4'h5);
        expect_b("b_rot1_right", 20'h51234, 4'h5);
        send_b(20'h12345, 2, 0, 1, 4'h6);
        expect_b("b_shift2_right", 20'h00123, 4'h6);

        p0 = b_pops;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    send_b(20'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 4'(i));
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    b_out_rdy = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
                b_out_rdy = 1'b1;
            end
        join
        drain(1);
        check("b_random_count", b_pops - p0, 80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rotate_pipe.md
Name: rotate_pipe

Overview:
- Pipelined, parametrised barrel rotator/shifter over a vector of NUM_UNITS units of UNIT_SIZE bits.
- Direction and mode (rotate vs zero-fill shift) are selected per transaction.
- valid/ready handshake with full backpressure, throughput 1 word/cycle, plus a sideband tag carried alongside the data.
- Used in datapath alignment (word/byte lane realignment of packet data) where a purely combinational rotate cannot meet timing.

Parameters:
- UNIT_SIZE, 8, bits per unit.
- NUM_UNITS, 4, units per word; must be >=2; need not be a power of two.
- INPUT_SIZE, UNIT_SIZE*NUM_UNITS, data width.
- ROTATE_SIZE, log2(NUM_UNITS) (ceiling), width of the rotation amount.
- REG_EVERY, 1, mux levels per register stage; range 1..ROTATE_SIZE.
- TAG_WIDTH, 1, sideband tag width.
- NUM_REGS, ceil(ROTATE_SIZE/REG_EVERY), derived; equals latency in cycles.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  [0:INPUT_SIZE-1]  unit 0 occupies bits [0:UNIT_SIZE-1]
- in_rotation  in  [ROTATE_SIZE-1:0]  amount in units
- in_dir  in  1  1=left, 0=right
- in_shift  in  1  1=logical shift (zero fill), 0=rotate
- in_tag  in  [TAG_WIDTH-1:0]  sideband, passed unchanged
- in_vld  in  1  input valid
- in_rdy  out  1  input ready
- out_data  out  [0:INPUT_SIZE-1]  result
- out_tag  out  [TAG_WIDTH-1:0]  tag of result
- out_vld  out  1  output valid
- out_rdy  in  1  downstream ready

Behaviour:
- Effective amount r = in_rotation mod NUM_UNITS for rotate.
  - Left: out unit j = in unit (j+r) mod N.
  - Right: out unit j = in unit (j-r) mod N.
- Shift mode: same indexing, but units sourced from beyond the vector are zero. in_rotation >= NUM_UNITS gives all-zero output.
- Implementation: ROTATE_SIZE log levels. Level k moves by 2^k units (mod N for rotate; zero-fill for shift, and all-zero if 2^k >= N) when rotation bit k is set.
  - Levels are processed LSB first.
  - A register follows every REG_EVERY levels; the last group is always registered, so the output is registered.
  - in_dir, in_shift, the remaining rotation bits and the tag travel with the data through each register.
- Transfers:
  - Input accepted on a clk edge with in_vld && in_rdy.
  - Output consumed on a clk edge with out_vld && out_rdy.
- Each register stage s holds vld_s.
  - Stage s loads when rdy_s = !vld_s || rdy_{s+1}, where rdy_{NUM_REGS} = out_rdy.
  - in_rdy = rdy_0. This is combinational from out_rdy; that path is accepted.
- Latency: NUM_REGS cycles from acceptance to out_vld when there are no stalls.
- Back-to-back: full throughput with out_rdy held high. No bubbles are inserted and no data is dropped or duplicated under any out_rdy pattern.
- Order is strictly preserved; out_tag always matches its data.
- out_data and out_tag are held stable while out_vld && !out_rdy.
- A stage with vld=0 may hold stale data; it is never presented because out_vld=0.
- Reset (asynchronous, immediate):
  - All vld bits go to 0, so out_vld=0.
  - out_data, out_tag and all stage data/control registers go to 0.
  - in_rdy=1 while reset is deasserted and the pipe is empty.
  - In-flight words are discarded; nothing is emitted after release until new input arrives.
- Simultaneous accept and consume in the same cycle is legal at every stage, and occupancy is unchanged.
- in_rotation=0 passes data through unchanged in either mode and direction.

Decomposition:
- Shared package/include holds:
  - the log2 (ceiling) function;
  - direction constants DIR_LEFT=1, DIR_RIGHT=0;
  - mode constants MODE_ROTATE=0, MODE_SHIFT=1.
- One sub-module: rotate_pipe_level, a single combinational mux level parametrised by unit distance 2^k, direction and shift-fill.
- rotate_pipe instantiates one rotate_pipe_level per level and owns the registers and handshake.

Test Plan:
All scenarios use UNIT_SIZE=8, NUM_UNITS=4, REG_EVERY=1 (latency 2) unless stated.
1. in_data=0x11223344, rot=1, dir=left, rotate -> out_data=0x22334411 exactly 2 cycles after accept; tag preserved.
2. Same data, rot=1, dir=right -> 0x44112233. Then rot=0 in both directions -> 0x11223344.
3. Shift: rot=3 left -> 0x44000000; rot=2 right -> 0x00001122.
4. Stream 16 words with increasing tags, out_rdy pattern 1,0,1,1,0,0,1... -> all 16 emitted in order with correct data/tag; out_data stable while stalled; throughput is 1/cycle once out_rdy is held at 1.
5. UNIT_SIZE=4, NUM_UNITS=5, REG_EVERY=2:
   - in_data=0x12345, rot=7, left, rotate -> 0x34512 (7 mod 5 = 2).
   - Same input in shift mode -> 0x00000.
   - Latency 2 cycles.
6. Assert reset with 2 words in flight and out_rdy=0 -> out_vld=0 and out_data=0 immediately (before the next clk edge); after release in_rdy=1 and no stale word ever appears.
